// File: rtl/vram_port_arbiter.sv
// Shares one async SRAM between LCD refill reads and queued spectrum writes.
// RdValid lands 2 cycles after RdAck; writes take WR1..WR3; WrFull backpressures writes, streak limit bounds reads.
module vram_port_arbiter #(
  parameter int BW_ADDR       = 18,
  parameter int BW_DATA       = 15,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int RD_STREAK_MAX = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               RdReq,
  input  logic [BW_ADDR-1:0] RdAddr,
  output logic               RdAck,
  output logic [BW_DATA-1:0] RdData,
  output logic               RdValid,
  input  logic               WrReq,
  input  logic [BW_ADDR-1:0] WrAddr,
  input  logic [BW_DATA-1:0] WrData,
  output logic               WrFull,
  output logic               nWE,
  output logic               nOE,
  output logic [BW_ADDR-1:0] SRAMAddr,
  inout  wire  [BW_DATA-1:0] SRAMIO,
  output logic               Idle
);

  localparam int PW = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
  localparam int SW = $clog2(RD_STREAK_MAX + 1);
  localparam int EW = BW_ADDR + BW_DATA;
  localparam logic [PW:0]   CNT_ONE    = 1;
  localparam logic [PW:0]   CNT_FULL   = (PW+1)'(WR_FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = 1;
  localparam logic [SW-1:0] STREAK_ONE = 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(RD_STREAK_MAX);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3} state_t;

  state_t            state;
  logic [EW-1:0]     fifo_mem [WR_FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count, count_nxt;
  logic [SW-1:0]     streak;
  logic [BW_DATA-1:0] io_dat;
  logic              io_en;
  logic              push, fifo_nempty, force_wr, grant_wr, grant_rd, idle_nxt;

  assign head   = fifo_mem[rd_ptr];
  assign SRAMIO = io_en ? io_dat : {BW_DATA{1'bz}};

  always_comb begin
    push        = WrReq && !WrFull;
    fifo_nempty = (count != '0);
    force_wr    = fifo_nempty && (streak == STREAK_MAX);
    grant_wr    = (state == IDLE) && fifo_nempty && (force_wr || !RdReq);
    grant_rd    = (state == IDLE) && RdReq && !force_wr;
    count_nxt   = count;
    if (push && !grant_wr)
      count_nxt = count + CNT_ONE;
    else if (!push && grant_wr)
      count_nxt = count - CNT_ONE;
    idle_nxt = (count_nxt == '0) &&
               (((state == IDLE) && !grant_rd && !grant_wr) || (state == RD2) || (state == WR3));
  end

  // WrFull tracks the post-edge occupancy, so a same-cycle pop cannot admit a push.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      WrFull <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_ONE;
      if (grant_wr) rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_nxt;
      WrFull <= (count_nxt == CNT_FULL);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= {WrAddr, WrData};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      nWE      <= 1'b1;
      nOE      <= 1'b1;
      SRAMAddr <= '0;
      io_dat   <= '0;
      io_en    <= 1'b0;
      RdAck    <= 1'b0;
      RdValid  <= 1'b0;
      RdData   <= '0;
      streak   <= '0;
      Idle     <= 1'b1;
    end else begin
      RdAck   <= 1'b0;
      RdValid <= 1'b0;
      Idle    <= idle_nxt;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state    <= WR1;
            SRAMAddr <= head[EW-1:BW_DATA];
            io_dat   <= head[BW_DATA-1:0];
            io_en    <= 1'b1;
            nWE      <= 1'b1;
            streak   <= '0;
          end else if (grant_rd) begin
            state    <= RD1;
            SRAMAddr <= RdAddr;
            nOE      <= 1'b0;
            RdAck    <= 1'b1;
            if (!fifo_nempty)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + STREAK_ONE;
          end
        end
        RD1: state <= RD2;
        RD2: begin
          RdData  <= SRAMIO;
          RdValid <= 1'b1;
          nOE     <= 1'b1;
          state   <= IDLE;
        end
        WR1: begin
          nWE   <= 1'b0;
          state <= WR2;
        end
        WR2: begin
          nWE   <= 1'b1;
          state <= WR3;
        end
        WR3: begin
          io_en <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
